// File: rtl/serial_twos_decoder.sv
// Serial two's-complement decoder: LSB-first frames in, negated
// parallel words out, with one word of holding space behind y.
module serial_twos_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             t_clock,
    input  logic             r_n,
    input  logic             i,
    input  logic             i_valid,
    input  logic             i_start,
    output logic             i_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             ovf,
    output logic             err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             seen_one;
    logic [WIDTH-1:0] sr;

    logic             take;
    logic             restart;
    logic             seen_eff;
    logic             dbit;
    logic             done;
    logic             slot_free;
    logic             y_fire;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] word;

    assign i_ready   = (state != HOLD);
    assign take      = i_valid && i_ready;
    assign restart   = take && i_start;
    assign y_fire    = y_valid && y_ready;
    assign slot_free = !y_valid || y_ready;

    // A start bit always decodes as if no 1 has been seen yet.
    assign seen_eff  = restart ? 1'b0 : seen_one;
    assign dbit      = seen_eff ? ~i : i;
    assign word      = {dbit, sr[WIDTH-1:1]};
    assign count_nxt = restart ? CW'(1) : count + CW'(1);
    assign done      = take && (state == RECV) && !i_start
                       && (count_nxt == LAST);

    always_ff @(posedge t_clock) begin
        if (!r_n) begin
            state    <= IDLE;
            count    <= '0;
            seen_one <= 1'b0;
            sr       <= '0;
            y        <= '0;
            y_valid  <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (y_fire) begin
                y_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (restart) begin
                        seen_one <= i;
                        sr       <= word;
                        count    <= count_nxt;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (take) begin
                        seen_one <= seen_eff | i;
                        sr       <= word;
                        count    <= count_nxt;
                        err      <= i_start;
                        if (done) begin
                            count <= '0;
                            if (slot_free) begin
                                y       <= word;
                                ovf     <= (word == MOST_NEG);
                                y_valid <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (y_fire) begin
                        y       <= sr;
                        ovf     <= (sr == MOST_NEG);
                        y_valid <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_twos_decoder.sv
// Bench for serial_twos_decoder: directed frames plus random traffic
// against a word-level model (expected word = -frame mod 2^W).
module tb_serial_twos_decoder;
    localparam int W = 8;
    localparam logic [W-1:0] MN = {1'b1, {(W-1){1'b0}}};

    logic         t_clock = 1'b0;
    logic         r_n     = 1'b0;
    logic         i       = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_start = 1'b0;
    logic         y_ready = 1'b0;
    logic         i_ready;
    logic         y_valid;
    logic         ovf;
    logic         err;
    logic [W-1:0] y;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] expq[$];
    logic [W-1:0] part;
    int           nbits    = 0;
    bit           in_frame = 1'b0;
    bit           err_exp  = 1'b0;

    serial_twos_decoder #(.WIDTH(W)) dut (
        .t_clock (t_clock),
        .r_n     (r_n),
        .i       (i),
        .i_valid (i_valid),
        .i_start (i_start),
        .i_ready (i_ready),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .ovf     (ovf),
        .err     (err)
    );

    always #5 t_clock = ~t_clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic step(input logic v, input logic b, input logic s,
                        input logic yr);
        bit           fire;
        bit           acc;
        logic [W-1:0] nv;
        i_valid = v;
        i       = b;
        i_start = s;
        y_ready = yr;
        #1;
        chk("err", 32'(err), 32'(err_exp));
        chk("i_ready", 32'(i_ready), 32'(expq.size() < 2));
        chk("y_valid", 32'(y_valid), 32'(expq.size() > 0));
        if (expq.size() > 0) begin
            chk("y", 32'(y), 32'(expq[0]));
            chk("ovf", 32'(ovf), 32'(expq[0] == MN));
        end
        fire    = yr && (expq.size() > 0);
        acc     = v && (expq.size() < 2);
        err_exp = 1'b0;
        if (fire) void'(expq.pop_front());
        if (acc) begin
            if (s) begin
                if (in_frame) err_exp = 1'b1;
                in_frame = 1'b1;
                part     = '0;
                part[0]  = b;
                nbits    = 1;
            end else if (in_frame) begin
                part[nbits] = b;
                nbits++;
            end
            if (in_frame && nbits == W) begin
                nv = '0 - part;
                expq.push_back(nv);
                in_frame = 1'b0;
                nbits    = 0;
            end
        end
        @(negedge t_clock);
    endtask

    task automatic do_reset(input logic v, input logic yr);
        r_n     = 1'b0;
        i_valid = v;
        i       = 1'b1;
        i_start = v;
        y_ready = yr;
        @(negedge t_clock);
        r_n = 1'b1;
        expq.delete();
        in_frame = 1'b0;
        nbits    = 0;
        err_exp  = 1'b0;
        #1;
        chk("rst_y", 32'(y), 32'(0));
        chk("rst_y_valid", 32'(y_valid), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_i_ready", 32'(i_ready), 32'(1));
    endtask

    task automatic send_frame(input logic [W-1:0] val, input logic yr);
        for (int k = 0; k < W; k++) begin
            step(1'b1, val[k], k == 0, yr);
        end
    endtask

    initial begin
        logic v;
        logic s;
        do_reset(1'b0, 1'b0);

        send_frame(8'hFA, 1'b1);
        chk("fa_y", 32'(y), 32'h06);
        chk("fa_yv", 32'(y_valid), 32'(1));
        chk("fa_ovf", 32'(ovf), 32'(0));
        step(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(8'h80, 1'b1);
        chk("80_y", 32'(y), 32'h80);
        chk("80_ovf", 32'(ovf), 32'(1));
        send_frame(8'h00, 1'b1);
        chk("00_y", 32'(y), 32'h00);
        chk("00_ovf", 32'(ovf), 32'(0));
        send_frame(8'h01, 1'b1);
        chk("01_y", 32'(y), 32'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(8'hFA, 1'b0);
        send_frame(8'hFF, 1'b0);
        chk("hold_y", 32'(y), 32'h06);
        chk("hold_i_ready", 32'(i_ready), 32'(0));
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("unhold_y", 32'(y), 32'h01);
        chk("unhold_yv", 32'(y_valid), 32'(1));
        chk("unhold_i_ready", 32'(i_ready), 32'(1));
        step(1'b0, 1'b0, 1'b0, 1'b1);

        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("abort_err", 32'(err), 32'(1));
        for (int k = 1; k < W; k++) begin
            step(1'b1, k[0] ? 1'b1 : 1'b1, 1'b0, 1'b1);
            if (k == 1) chk("abort_err_once", 32'(err), 32'(0));
        end
        chk("abort_y", 32'(y), 32'h02);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, k == 0, 1'b1);
        end
        do_reset(1'b1, 1'b1);
        send_frame(8'h03, 1'b1);
        chk("rst_abort_y", 32'(y), 32'hFD);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
        end
        chk("ignore_yv", 32'(y_valid), 32'(0));
        send_frame(8'hFA, 1'b1);
        chk("ignore_y", 32'(y), 32'h06);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1'($urandom), 1'($urandom));
            end else begin
                v = ($urandom_range(0, 3) != 0);
                if (in_frame) s = v && ($urandom_range(0, 19) == 0);
                else s = v && ($urandom_range(0, 2) == 0);
                step(v, 1'($urandom), s, 1'($urandom_range(0, 2) != 0));
            end
        end
        for (int n = 0; n < 4; n++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
